// File: rtl/pc_sequencer.sv
// Fetch program counter: sequential step, stall, branch/call/return redirect, target alignment check.
// Optional return-address stack is built only when PC_SEQ_RAS_EN is defined.
module pc_sequencer #(
  parameter int              PC_W      = 64,
  parameter int              STEP      = 4,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            call,
  input  logic            ret,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] adder_out,
  output logic            pc_valid,
  output logic            misalign,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_overflow,
  output logic            ras_underflow
);

  localparam logic [PC_W-1:0] STEP_V   = PC_W'(STEP);
  localparam logic [PC_W-1:0] LOW_MASK = PC_W'(STEP - 1);

  if (STEP < 1 || (STEP & (STEP - 1)) != 0) begin : g_bad_step
    $error("pc_sequencer: STEP must be a power of two");
  end
  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pc_sequencer: RAS_DEPTH must be a power of two, at least 2");
  end

  logic [PC_W-1:0] target_aligned;
  logic            ras_has;
  logic [PC_W-1:0] ras_top;

  assign adder_out      = pc_out + STEP_V;
  assign target_aligned = br_target & ~LOW_MASK;

`ifdef PC_SEQ_RAS_EN
  localparam int              PTR_W    = $clog2(RAS_DEPTH);
  localparam int              CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top;
  logic [PTR_W-1:0] top_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             do_call;
  logic             do_ret;

  assign accept    = pc_valid && !stall;
  assign do_ret    = accept && ret;
  assign do_call   = accept && !ret && call;
  assign top_nxt   = top + 1'b1;
  assign ras_has   = (cnt != '0);
  assign ras_top   = ras_mem[top];
  assign ras_empty = (cnt == '0);
  assign ras_full  = (cnt == FULL_CNT);

  // A push into a full stack lands on the oldest slot because the buffer is circular.
  always_ff @(posedge clk) begin
    if (do_call) begin
      ras_mem[top_nxt] <= adder_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top           <= '0;
      cnt           <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      ras_underflow <= do_ret && !ras_has;
      if (do_call) begin
        top <= top_nxt;
        if (cnt == FULL_CNT) begin
          ras_overflow <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (do_ret && ras_has) begin
        top <= top - 1'b1;
        cnt <= cnt - 1'b1;
      end
    end
  end
`else
  assign ras_has       = 1'b0;
  assign ras_top       = '0;
  assign ras_empty     = 1'b1;
  assign ras_full      = 1'b0;
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
`endif

  // The first edge out of reset only raises pc_valid; controls are ignored until then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out   <= RESET_VEC;
      pc_valid <= 1'b0;
      misalign <= 1'b0;
    end else if (!pc_valid) begin
      pc_valid <= 1'b1;
    end else begin
      misalign <= 1'b0;
      if (!stall) begin
        if (ret) begin
          pc_out <= ras_has ? ras_top : adder_out;
        end else if (call || br_taken) begin
          pc_out   <= target_aligned;
          misalign <= |(br_target & LOW_MASK);
        end else begin
          pc_out <= adder_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; expectations follow whether PC_SEQ_RAS_EN is defined.
module tb_pc_sequencer;
  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic        call;
  logic        ret;
  logic [31:0] br_target;
  logic [31:0] pc_out;
  logic [31:0] adder_out;
  logic        pc_valid, misalign, ras_empty, ras_full, ras_overflow, ras_underflow;
  logic [15:0] w_pc, w_add;
  logic        w_valid, w_mis, w_emp, w_full, w_ovf, w_unf;

  int checks = 0;
  int errors = 0;

`ifdef PC_SEQ_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        vld, mis, emp, full, ovf, unf;
  } exp_t;

  exp_t sb[$];

  pc_sequencer #(.PC_W(32), .STEP(4), .RESET_VEC(32'h100), .RAS_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .call(call), .ret(ret), .pc_out(pc_out), .adder_out(adder_out), .pc_valid(pc_valid),
    .misalign(misalign), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  pc_sequencer #(.PC_W(16), .STEP(4), .RESET_VEC(16'hFFF8)) u_w16 (
    .clk(clk), .rst(rst), .stall(1'b0), .br_taken(1'b0), .br_target(16'h0000),
    .call(1'b0), .ret(1'b0), .pc_out(w_pc), .adder_out(w_add), .pc_valid(w_valid),
    .misalign(w_mis), .ras_empty(w_emp), .ras_full(w_full),
    .ras_overflow(w_ovf), .ras_underflow(w_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic b, input logic c, input logic r,
                       input logic [31:0] t);
    stall = s; br_taken = b; call = c; ret = r; br_target = t;
  endtask

  // Queue the expectation for the inputs just driven, then compare after the edge.
  task automatic tick(input string tag, input logic [31:0] pc, input logic vld,
                      input logic mis, input logic emp, input logic full,
                      input logic ovf, input logic unf);
    exp_t e;
    e.tag = tag; e.pc = pc; e.vld = vld; e.mis = mis;
    e.emp = emp; e.full = full; e.ovf = ovf; e.unf = unf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".pc"},   pc_out,               e.pc);
    chk({e.tag, ".add"},  adder_out,            e.pc + 32'd4);
    chk({e.tag, ".vld"},  {31'd0, pc_valid},      {31'd0, e.vld});
    chk({e.tag, ".mis"},  {31'd0, misalign},      {31'd0, e.mis});
    chk({e.tag, ".emp"},  {31'd0, ras_empty},     {31'd0, e.emp});
    chk({e.tag, ".full"}, {31'd0, ras_full},      {31'd0, e.full});
    chk({e.tag, ".ovf"},  {31'd0, ras_overflow},  {31'd0, e.ovf});
    chk({e.tag, ".unf"},  {31'd0, ras_underflow}, {31'd0, e.unf});
  endtask

  initial begin
    logic [31:0] p;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #3;
    chk("rst.pc",  pc_out, 32'h100);
    chk("rst.add", adder_out, 32'h104);
    chk("rst.vld", {31'd0, pc_valid}, 32'd0);
    chk("rst.emp", {31'd0, ras_empty}, 32'd1);
    chk("rst.ovf", {31'd0, ras_overflow}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Startup: first edge validates, then sequential stepping; 16-bit copy wraps.
    tick("start1", 32'h100, 1, 0, 1, 0, 0, 0);
    chk("w16.pc1", {16'd0, w_pc}, 32'hFFF8);
    chk("w16.vld", {31'd0, w_valid}, 32'd1);
    tick("start2", 32'h104, 1, 0, 1, 0, 0, 0);
    chk("w16.pc2", {16'd0, w_pc}, 32'hFFFC);
    chk("w16.add", {16'd0, w_add}, 32'h0000);
    tick("start3", 32'h108, 1, 0, 1, 0, 0, 0);
    chk("w16.wrap", {16'd0, w_pc}, 32'h0000);

    // Branch, stall (with a competing branch held off), misaligned branch.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h2000);
    tick("br", 32'h2000, 1, 0, 1, 0, 0, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h5000);
    for (int i = 0; i < 3; i++) tick("stall", 32'h2000, 1, 0, 1, 0, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h3002);
    tick("mis", 32'h3000, 1, 1, 1, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick("mis_off", 32'h3004, 1, 0, 1, 0, 0, 0);

    // Call then immediate return.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h40);
    tick("br40", 32'h40, 1, 0, 1, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h800);
    tick("call", 32'h800, 1, 0, !RAS, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    p = RAS ? 32'h44 : 32'h804;
    tick("ret", p, 1, 0, 1, 0, 0, 0);

    // ret+call+br together on an empty stack: ret wins, misaligned target ignored.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h9002);
    p = p + 32'd4;
    tick("simul", p, 1, 0, 1, 0, 0, RAS);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    p = p + 32'd4;
    tick("simul_off", p, 1, 0, 1, 0, 0, 0);

    // Five nested calls into a four-deep stack, then five returns.
    for (int k = 1; k <= 5; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'(k) * 32'h1000);
      tick("ncall", 32'(k) * 32'h1000, 1, 0, !RAS, RAS && k >= 4, RAS && k == 5, 0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    for (int j = 0; j < 4; j++) begin
      p = RAS ? 32'(4 - j) * 32'h1000 + 32'd4 : 32'h5000 + 32'd4 * 32'(j + 1);
      tick("nret", p, 1, 0, RAS ? (j == 3) : 1'b1, 0, RAS, 0);
    end
    p = p + 32'd4;
    tick("uflow", p, 1, 0, 1, 0, RAS, RAS);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    tick("uflow_stall", p, 1, 0, 1, 0, RAS, 0);

    // Asynchronous reset in the middle of a call cycle.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h700);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.pc",  pc_out, 32'h100);
    chk("arst.vld", {31'd0, pc_valid}, 32'd0);
    chk("arst.emp", {31'd0, ras_empty}, 32'd1);
    chk("arst.ovf", {31'd0, ras_overflow}, 32'd0);
    @(posedge clk);
    #1;
    chk("arst.hold", pc_out, 32'h100);
    rst = 1'b0;
    tick("arst.first", 32'h100, 1, 0, 1, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick("arst.seq", 32'h104, 1, 0, 1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
